// File: rtl/p_fxp_acc_seq.sv
// p_fxp_acc_seq: multi-beat accumulation sequencer for the fixed-point adder tree.
// Each beat of IN elements is reduced by p_fxp_acc. The beat sum is added into a running
// partial sum with p_fxp_add. The final sum is presented with a sticky overflow flag.
// The package, the saturating adder and the tree are kept in this file so that it is self-contained.
//
// Handshake rules (both ports): a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge. Ready may be high
// without valid. in_ready and out_valid are registered and only change on clock edges.

package p_fxp_pkg;
  // Fixed-point format: total width and number of fractional bits.
  typedef struct packed {
    int prec;
    int frac;
  } fxp_conf_t;

  localparam fxp_conf_t DCONF_FXP = '{prec: 16, frac: 8};
endpackage

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP p_fxp_pkg::DCONF_FXP
`endif

// p_fxp_add: two's-complement add of two values in the same format, saturating to the
// representable range. ovf flags any clipping, udf flags clipping at the negative bound, and
// rounded is always 0 because input and output formats are identical.
module p_fxp_add #(
  parameter p_fxp_pkg::fxp_conf_t CONF = `DEF_DCONF_FXP,
  localparam int PREC = CONF.prec
) (
  input  logic [PREC-1:0] a,
  input  logic [PREC-1:0] b,
  output logic [PREC-1:0] y,
  output logic            ovf,
  output logic            udf,
  output logic            rounded
);
  logic [PREC:0] sum_w;

  assign sum_w = {a[PREC-1], a} + {b[PREC-1], b};

  // Detect sign disagreement between the guard bit and the result MSB, then clip.
  always_comb begin
    ovf     = sum_w[PREC] ^ sum_w[PREC-1];
    udf     = ovf & sum_w[PREC];
    rounded = 1'b0;
    if (ovf) begin
      y = sum_w[PREC] ? {1'b1, {(PREC-1){1'b0}}} : {1'b0, {(PREC-1){1'b1}}};
    end else begin
      y = sum_w[PREC-1:0];
    end
  end
endmodule

// p_fxp_acc: balanced binary adder tree over IN elements. The tree is padded with zeros up to
// the next power of two. Every node is a saturating p_fxp_add, so a clipped stage propagates
// its clipped value upward. The flags are the OR over all nodes.
module p_fxp_acc #(
  parameter int IN = 8,
  parameter p_fxp_pkg::fxp_conf_t CONF = `DEF_DCONF_FXP,
  localparam int PREC = CONF.prec
) (
  input  logic [IN-1:0][PREC-1:0] in_data,
  output logic [PREC-1:0]         sum,
  output logic                    ovf,
  output logic                    udf,
  output logic                    rounded
);
  localparam int LVL = (IN > 1) ? $clog2(IN) : 0;
  localparam int N   = 1 << LVL;

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [PREC-1:0] v [N >> l];
    logic            ovf_c;
    logic            udf_c;
    logic            rnd_c;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_in
        if (i < IN) begin : g_real
          assign v[i] = in_data[i];
        end else begin : g_pad
          assign v[i] = '0;
        end
      end
      assign ovf_c = 1'b0;
      assign udf_c = 1'b0;
      assign rnd_c = 1'b0;
    end else begin : g_node
      logic [(N >> l)-1:0] ovf_l;
      logic [(N >> l)-1:0] udf_l;
      logic [(N >> l)-1:0] rnd_l;

      for (genvar k = 0; k < (N >> l); k++) begin : g_add
        p_fxp_add #(.CONF(CONF)) u_add (
          .a       (g_lvl[l-1].v[2*k]),
          .b       (g_lvl[l-1].v[2*k+1]),
          .y       (v[k]),
          .ovf     (ovf_l[k]),
          .udf     (udf_l[k]),
          .rounded (rnd_l[k])
        );
      end
      assign ovf_c = g_lvl[l-1].ovf_c | (|ovf_l);
      assign udf_c = g_lvl[l-1].udf_c | (|udf_l);
      assign rnd_c = g_lvl[l-1].rnd_c | (|rnd_l);
    end
  end

  assign sum     = g_lvl[LVL].v[0];
  assign ovf     = g_lvl[LVL].ovf_c;
  assign udf     = g_lvl[LVL].udf_c;
  assign rounded = g_lvl[LVL].rnd_c;
endmodule

// p_fxp_acc_seq: IDLE -> ACC (one accepted beat per cycle, counted down) -> DONE (hold the
// result until the output handshake) -> IDLE. The dbg_state and dbg_cnt outputs expose the
// sequencer for observation only.
module p_fxp_acc_seq #(
  parameter int IN = 8,
  parameter p_fxp_pkg::fxp_conf_t CONF = `DEF_DCONF_FXP,
  parameter int BEATW = 8,
  localparam int PREC = CONF.prec
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    start,
  input  logic [BEATW-1:0]        beats,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN-1:0][PREC-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PREC-1:0]         out_data,
  output logic                    out_ovf,
  output logic [1:0]              dbg_state,
  output logic [BEATW-1:0]        dbg_cnt
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BEATW-1:0] cnt_q, cnt_d;
  logic [PREC-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [PREC-1:0] tree_sum;
  logic            tree_ovf, tree_udf, tree_rnd;
  logic [PREC-1:0] add_y;
  logic            add_ovf, add_udf, add_rnd;
  logic            beat_acc;
  logic            unused_flags;

  p_fxp_acc #(.IN(IN), .CONF(CONF)) u_tree (
    .in_data (in_data),
    .sum     (tree_sum),
    .ovf     (tree_ovf),
    .udf     (tree_udf),
    .rounded (tree_rnd)
  );

  p_fxp_add #(.CONF(CONF)) u_psum (
    .a       (acc_q),
    .b       (tree_sum),
    .y       (add_y),
    .ovf     (add_ovf),
    .udf     (add_udf),
    .rounded (add_rnd)
  );

  // Only overflow feeds the sticky flag; the other submodule flags are deliberately dropped.
  assign unused_flags = ^{tree_udf, tree_rnd, add_udf, add_rnd};

  assign beat_acc = in_valid & in_ready_q;

  // Next-state and next-datapath values; handshake outputs are derived from the next state
  // so they are registered and change together with the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (beats != '0) begin
            state_d = ACC;
            cnt_d   = beats;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (beat_acc) begin
          acc_d = add_y;
          ovf_d = ovf_q | tree_ovf | add_ovf;
          cnt_d = cnt_q - BEATW'(1);
          if (cnt_q == BEATW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
endmodule

// File: tb/tb_p_fxp_acc_seq.sv
// tb_p_fxp_acc_seq: directed bench for p_fxp_acc_seq (IN=8, 16-bit format, 8-bit beat count).
// The behavioural model computes each run's result with integer arithmetic and saturation.
// It pushes {ovf, data} into exp_q. A negedge compare process checks every cycle with
// out_valid high against the head of the queue.
module tb_p_fxp_acc_seq;
  localparam int IN    = 8;
  localparam int PREC  = 16;
  localparam int BEATW = 8;
  localparam int MAXV  = 32767;
  localparam int MINV  = -32768;

  typedef logic [IN-1:0][PREC-1:0] beat_t;

  logic             clk;
  logic             reset_;
  logic             start;
  logic [BEATW-1:0] beats;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  beat_t            in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PREC-1:0]  out_data;
  logic             out_ovf;
  logic [1:0]       dbg_state;
  logic [BEATW-1:0] dbg_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [PREC:0] exp_q[$];
  beat_t         beat_buf[$];

  p_fxp_acc_seq dut (
    .clk       (clk),
    .reset_    (reset_),
    .start     (start),
    .beats     (beats),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Checks
  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Model
  function automatic void sat_add(input int a, input int b, output int y, output bit o);
    int s;
    s = a + b;
    o = 1'b0;
    if (s > MAXV) begin
      y = MAXV;
      o = 1'b1;
    end else if (s < MINV) begin
      y = MINV;
      o = 1'b1;
    end else begin
      y = s;
    end
  endfunction

  function automatic void beat_model(input beat_t d, output int s, output bit o);
    int v[IN];
    int n;
    int y;
    bit oo;
    for (int i = 0; i < IN; i++) v[i] = $signed(d[i]);
    o = 1'b0;
    n = IN;
    while (n > 1) begin
      for (int k = 0; k < n / 2; k++) begin
        sat_add(v[2*k], v[2*k+1], y, oo);
        v[k] = y;
        o = o | oo;
      end
      n = n / 2;
    end
    s = v[0];
  endfunction

  function automatic void run_model(output int s, output bit o);
    int acc;
    int bs;
    int y;
    bit bo;
    bit ao;
    acc = 0;
    o = 1'b0;
    foreach (beat_buf[b]) begin
      beat_model(beat_buf[b], bs, bo);
      sat_add(acc, bs, y, ao);
      acc = y;
      o = o | bo | ao;
    end
    s = acc;
  endfunction

  function automatic beat_t fill(input int v);
    beat_t r;
    for (int i = 0; i < IN; i++) r[i] = v[PREC-1:0];
    return r;
  endfunction

  function automatic void push_exp(input int s, input bit o);
    logic [PREC:0] e;
    e[PREC]     = o;
    e[PREC-1:0] = s[PREC-1:0];
    exp_q.push_back(e);
  endfunction

  // Scoreboard compare process
  always @(negedge clk) begin
    if (reset_ === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cmp_unexpected: out_valid high with no result expected");
      end else begin
        check("cmp_out_data", $signed(out_data), $signed(exp_q[0][PREC-1:0]));
        check("cmp_out_ovf", out_ovf, exp_q[0][PREC]);
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-rate run of beat_buf: start, one beat per cycle, check latency, then handshake.
  task automatic run_full(input string tag, output int s, output bit o);
    int nb;
    nb = beat_buf.size();
    run_model(s, o);
    push_exp(s, o);
    start = 1'b1;
    beats = BEATW'(nb);
    tick();
    start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1;
      in_data  = beat_buf[b];
      tick();
      in_valid = 1'b0;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  // Stimulus
  initial begin
    int s;
    bit o;
    beat_t ba;
    reset_    = 1'b0;
    start     = 1'b0;
    beats     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values with random inputs
    for (int c = 0; c < 3; c++) begin
      start     = 1'($urandom_range(0, 1));
      beats     = BEATW'($urandom_range(0, 255));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < IN; i++) in_data[i] = PREC'($urandom_range(0, 65535));
      tick();
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_out_data", out_data, 0);
    end
    reset_    = 1'b1;
    start     = 1'b0;
    beats     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    tick();
    check("post_rst_busy", busy, 0);

    // Three beats at full rate, then a held result
    beat_buf = {fill(1), fill(2), fill(-1)};
    run_model(s, o);
    check("model_three_sum", s, 16);
    check("model_three_ovf", o, 0);
    push_exp(s, o);
    start = 1'b1;
    beats = 8'd3;
    tick();
    start = 1'b0;
    check("three_busy", busy, 1);
    check("three_out_valid_early", out_valid, 0);
    for (int b = 0; b < 3; b++) begin
      check("three_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = beat_buf[b];
      tick();
      in_valid = 1'b0;
    end
    check("three_out_valid_lat4", out_valid, 1);
    check("three_in_ready_off", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      check("three_hold_data", $signed(out_data), 16);
      check("three_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("three_after_hs_valid", out_valid, 0);
    check("three_after_hs_busy", busy, 0);

    // Bubbles: in_valid 1,0,0,1
    for (int i = 0; i < IN; i++) ba[i] = PREC'(i + 1);
    beat_buf = {ba, fill(-3)};
    run_model(s, o);
    check("model_bubble_sum", s, 12);
    push_exp(s, o);
    start = 1'b1;
    beats = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = beat_buf[0];
    tick();
    in_valid = 1'b0;
    in_data  = fill(100);
    check("bubble_cnt_idle1", dbg_cnt, 1);
    tick();
    check("bubble_cnt_idle2", dbg_cnt, 1);
    check("bubble_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b1;
    in_data  = beat_buf[1];
    tick();
    in_valid = 1'b0;
    check("bubble_out_valid", out_valid, 1);
    check("bubble_cnt_end", dbg_cnt, 0);
    check("bubble_sum", $signed(out_data), 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Overflow, then a clean run clears the flag
    beat_buf = {fill(8191), fill(8191)};
    run_full("ovf", s, o);
    check("model_ovf_sum", s, 32767);
    check("model_ovf_flag", o, 1);
    beat_buf = {fill(5)};
    run_full("clean", s, o);
    check("model_clean_sum", s, 40);
    check("model_clean_flag", o, 0);

    // Starts ignored in ACC and DONE
    beat_buf = {fill(3), fill(4)};
    run_model(s, o);
    check("model_ign_sum", s, 56);
    push_exp(s, o);
    start = 1'b1;
    beats = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = beat_buf[0];
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    beats = 8'd9;
    tick();
    start = 1'b0;
    check("ign_acc_cnt", dbg_cnt, 1);
    check("ign_acc_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = beat_buf[1];
    tick();
    in_valid = 1'b0;
    check("ign_out_valid", out_valid, 1);
    start = 1'b1;
    beats = 8'd4;
    tick();
    start = 1'b0;
    check("ign_done_valid", out_valid, 1);
    check("ign_done_in_ready", in_ready, 0);
    check("ign_done_cnt", dbg_cnt, 0);
    check("ign_done_data", $signed(out_data), 56);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero-beat run
    beat_buf.delete();
    push_exp(0, 1'b0);
    start = 1'b1;
    beats = 8'd0;
    tick();
    start = 1'b0;
    check("zero_out_valid", out_valid, 1);
    check("zero_in_ready", in_ready, 0);
    check("zero_out_data", out_data, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_in_ready_after", in_ready, 0);
    check("zero_busy_after", busy, 0);

    // Reset mid-run after 2 of 4 beats, with a beat presented during reset
    start = 1'b1;
    beats = 8'd4;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = fill(10);
      tick();
    end
    reset_ = 1'b0;
    tick();
    reset_   = 1'b1;
    in_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_acc", out_data, 0);
    check("midrst_cnt", dbg_cnt, 0);
    beat_buf = {fill(7)};
    run_full("post_rst", s, o);
    check("model_post_rst_sum", s, 56);

    tick();
    check("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
